// File: rtl/multi_gate_unit.sv
// Multi-channel logic-gate unit: per-channel runtime-selectable reduction gate,
// two-stage valid-qualified pipeline and saturating per-channel toggle counters.
module multi_gate_unit #(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned INPUTS   = 4,
   parameter int unsigned CNT_W    = 8,
   localparam int unsigned MCH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [CHANNELS*INPUTS-1:0]   in_bus,
   input  logic                         in_valid,
   input  logic                         mode_wr,
   input  logic [MCH_W-1:0]             mode_ch,
   input  logic [2:0]                   mode_data,
   input  logic                         cnt_clr,
   output logic [CHANNELS-1:0]          y,
   output logic                         y_valid,
   output logic [CHANNELS*CNT_W-1:0]    toggle_cnt
);

   localparam logic [2:0] MODE_AND  = 3'b000;
   localparam logic [2:0] MODE_NAND = 3'b001;
   localparam logic [2:0] MODE_OR   = 3'b010;
   localparam logic [2:0] MODE_NOR  = 3'b011;
   localparam logic [2:0] MODE_XOR  = 3'b100;
   localparam logic [2:0] MODE_XNOR = 3'b101;
   localparam logic [2:0] MODE_BUF  = 3'b110;

   logic [CHANNELS-1:0][2:0]        mode_q, mode_d;
   logic [CHANNELS-1:0][2:0]        s1_mode_q, s1_mode_d;
   logic [CHANNELS*INPUTS-1:0]      s1_data_q, s1_data_d;
   logic                            s1_valid_q, s1_valid_d;
   logic [CHANNELS-1:0]             y_q, y_d;
   logic                            y_valid_q, y_valid_d;
   logic [CHANNELS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
   logic [CHANNELS-1:0]             eval_y;

   function automatic logic gate_eval(input logic [2:0] code, input logic [INPUTS-1:0] d);
      case (code)
         MODE_AND:  return &d;
         MODE_NAND: return ~&d;
         MODE_OR:   return |d;
         MODE_NOR:  return ~|d;
         MODE_XOR:  return ^d;
         MODE_XNOR: return ~^d;
         MODE_BUF:  return d[0];
         default:   return ~d[0];
      endcase
   endfunction

   always_comb begin
      mode_d     = mode_q;
      s1_valid_d = in_valid;
      s1_data_d  = in_valid ? in_bus : s1_data_q;
      // Snapshot taken from the pre-write mode registers, so a same-edge write
      // only affects later captures.
      s1_mode_d  = in_valid ? mode_q : s1_mode_q;
      y_valid_d  = s1_valid_q;
      y_d        = y_q;
      cnt_d      = cnt_q;
      eval_y     = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (mode_wr && (32'(mode_ch) == c))
            mode_d[c] = mode_data;
         eval_y[c] = gate_eval(s1_mode_q[c], s1_data_q[c*INPUTS +: INPUTS]);
         if (s1_valid_q)
            y_d[c] = eval_y[c];
         if (cnt_clr)
            cnt_d[c] = '0;
         else if (s1_valid_q && (eval_y[c] != y_q[c]) && (cnt_q[c] != '1))
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q     <= {CHANNELS{MODE_NAND}};
         s1_mode_q  <= '0;
         s1_data_q  <= '0;
         s1_valid_q <= 1'b0;
         y_q        <= '0;
         y_valid_q  <= 1'b0;
         cnt_q      <= '0;
      end else begin
         mode_q     <= mode_d;
         s1_mode_q  <= s1_mode_d;
         s1_data_q  <= s1_data_d;
         s1_valid_q <= s1_valid_d;
         y_q        <= y_d;
         y_valid_q  <= y_valid_d;
         cnt_q      <= cnt_d;
      end
   end

   assign y          = y_q;
   assign y_valid    = y_valid_q;
   assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_multi_gate_unit.sv
// Scoreboard bench for multi_gate_unit: a per-cycle behavioural model pushes
// expected outputs; a negedge monitor pops and compares on y_valid.
module tb_multi_gate_unit;
   localparam int CH = 3;
   localparam int IN = 4;
   localparam int CW = 2;
   localparam int MW = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic                clk = 1'b0;
   logic                reset;
   logic [CH*IN-1:0]    in_bus;
   logic                in_valid;
   logic                mode_wr;
   logic [MW-1:0]       mode_ch;
   logic [2:0]          mode_data;
   logic                cnt_clr;
   logic [CH-1:0]       y;
   logic                y_valid;
   logic [CH*CW-1:0]    toggle_cnt;

   multi_gate_unit #(.CHANNELS(CH), .INPUTS(IN), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .in_bus(in_bus), .in_valid(in_valid),
      .mode_wr(mode_wr), .mode_ch(mode_ch), .mode_data(mode_data),
      .cnt_clr(cnt_clr), .y(y), .y_valid(y_valid), .toggle_cnt(toggle_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               edge_no;
      logic [CH-1:0]    y;
      logic [CH*CW-1:0] cnt;
   } exp_t;

   exp_t sbq[$];
   int checks = 0;
   int failures = 0;
   int edge_cnt = 0;

   // Behavioural model state
   int            m_mode[CH];
   logic [CH-1:0] m_y;
   int            m_cnt[CH];
   bit            p_valid;
   logic [IN-1:0] p_data[CH];
   int            p_mode[CH];

   always @(posedge clk) edge_cnt++;

   function automatic void check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at edge %0d", name, act, exp, edge_cnt);
      end
   endfunction

   function automatic logic gate_ref(input int code, input logic [IN-1:0] d);
      int ones;
      ones = $countones(d);
      case (code)
         0: return ones == IN;
         1: return ones != IN;
         2: return ones != 0;
         3: return ones == 0;
         4: return (ones % 2) == 1;
         5: return (ones % 2) == 0;
         6: return d[0];
         default: return !d[0];
      endcase
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < CH; c++) begin
         m_mode[c] = 1;
         m_cnt[c]  = 0;
         p_mode[c] = 0;
         p_data[c] = '0;
      end
      m_y = '0;
      p_valid = 0;
      sbq.delete();
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         while (sbq.size() > 0 && sbq[0].edge_no < edge_cnt) begin
            check("missing_y_valid", 0, 1);
            void'(sbq.pop_front());
         end
         if (y_valid) begin
            if (sbq.size() == 0 || sbq[0].edge_no != edge_cnt) begin
               check("unexpected_y_valid", 1, 0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check("y", y, e.y);
               check("toggle_cnt", toggle_cnt, e.cnt);
            end
         end
      end
   end

   task automatic cycle(input bit v, input logic [CH*IN-1:0] d, input bit wr,
                        input int ch, input int md, input bit clr);
      int e;
      logic [CH-1:0] ny;
      exp_t ent;
      in_valid  = v;
      in_bus    = d;
      mode_wr   = wr;
      mode_ch   = MW'(ch);
      mode_data = 3'(md);
      cnt_clr   = clr;
      e = edge_cnt + 1;
      if (p_valid) begin
         for (int c = 0; c < CH; c++) begin
            ny[c] = gate_ref(p_mode[c], p_data[c]);
            if (clr) m_cnt[c] = 0;
            else if (ny[c] != m_y[c] && m_cnt[c] < CMAX) m_cnt[c]++;
         end
         m_y = ny;
         ent.edge_no = e;
         ent.y = m_y;
         for (int c = 0; c < CH; c++) ent.cnt[c*CW +: CW] = CW'(m_cnt[c]);
         sbq.push_back(ent);
      end else if (clr) begin
         for (int c = 0; c < CH; c++) m_cnt[c] = 0;
      end
      p_valid = v;
      if (v) begin
         for (int c = 0; c < CH; c++) begin
            p_data[c] = d[c*IN +: IN];
            p_mode[c] = m_mode[c];
         end
      end
      if (wr && ch < CH) m_mode[ch] = md;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, 0, 0);
   endtask

   function automatic logic [CH*IN-1:0] pack3(input logic [IN-1:0] c2, input logic [IN-1:0] c1,
                                              input logic [IN-1:0] c0);
      return {c2, c1, c0};
   endfunction

   initial begin
      reset = 1'b1;
      in_bus = '0; in_valid = 0; mode_wr = 0; mode_ch = '0; mode_data = '0; cnt_clr = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_y", y, 0);
      check("reset_y_valid", y_valid, 0);
      check("reset_cnt", toggle_cnt, 0);
      @(negedge clk);
      reset = 1'b0;

      // Reset-default NAND behaviour
      cycle(1, pack3(4'b0000, 4'b0001, 4'b1111), 0, 0, 0, 0);
      cycle(1, pack3(4'b0000, 4'b0111, 4'b1100), 0, 0, 0, 0);
      idle(1);
      check("default_nand_y", y, 3'b111);
      check("default_nand_cnt", toggle_cnt, {2'd1, 2'd1, 2'd1});

      // Every mode on ch0 with 0110
      for (int md = 0; md < 8; md++) begin
         cycle(0, '0, 1, 0, md, 0);
         cycle(1, pack3(4'b1010, 4'b1111, 4'b0110), 0, 0, 0, 0);
      end
      idle(1);

      // Same-edge mode write and capture
      cycle(0, '0, 1, 0, 1, 0);
      cycle(1, pack3(4'b0000, 4'b0000, 4'b0000), 1, 0, 2, 0);
      idle(1);
      check("race_old_mode", y[0], 1);
      cycle(1, pack3(4'b0000, 4'b0000, 4'b0000), 0, 0, 0, 0);
      idle(1);
      check("race_new_mode", y[0], 0);

      // Bubble and hold
      cycle(1, pack3(4'b1111, 4'b0011, 4'b0101), 0, 0, 0, 0);
      cycle(0, pack3(4'b0000, 4'b1111, 4'b1111), 0, 0, 0, 0);
      cycle(1, pack3(4'b0001, 4'b1111, 4'b0000), 0, 0, 0, 0);
      idle(2);

      // Saturation and clear on ch0 (AND mode)
      cycle(0, '0, 1, 0, 0, 1);
      for (int i = 0; i < 6; i++)
         cycle(1, pack3(4'b0000, 4'b0000, (i % 2 == 0) ? 4'b1111 : 4'b0000), 0, 0, 0, 0);
      idle(1);
      check("sat_cnt0", toggle_cnt[CW-1:0], CMAX);
      cycle(1, pack3(4'b0000, 4'b0000, 4'b1111), 0, 0, 0, 0);
      cycle(0, '0, 0, 0, 0, 1);
      check("clr_over_inc", toggle_cnt[CW-1:0], 0);
      check("clr_y_kept", y[0], 1);
      idle(1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 3) != 0), CH*IN'($urandom), ($urandom_range(0, 3) == 0),
               $urandom_range(0, 3), $urandom_range(0, 7), ($urandom_range(0, 15) == 0));
      end
      idle(2);

      // Asynchronous reset between capture and y update
      cycle(1, pack3(4'b0000, 4'b0000, 4'b0000), 0, 0, 0, 0);
      cycle(1, pack3(4'b0000, 4'b0000, 4'b0000), 0, 0, 0, 0);
      #2 reset = 1'b1;
      #1;
      check("async_reset_y", y, 0);
      check("async_reset_y_valid", y_valid, 0);
      check("async_reset_cnt", toggle_cnt, 0);
      model_reset();
      in_valid = 0;
      @(negedge clk);
      reset = 1'b0;
      idle(2);
      check("no_inflight_y", y, 0);

      // Out-of-range channel write has no effect; modes back to NAND
      cycle(0, '0, 1, 3, 0, 0);
      cycle(1, pack3(4'b1111, 4'b0001, 4'b1111), 0, 0, 0, 0);
      idle(1);
      check("post_reset_nand", y, 3'b010);
      idle(2);

      check("scoreboard_drained", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule
